// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA timing constants and decoder state encoding, used by both the
// generator side and vga_sync_decoder.
package vga_sync_decoder_pkg;

  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;

  localparam int CNT_W = 10;
  localparam int FC_W  = 16;

  // Bit positions of the sampled VGA inputs in the edge-detector bank
  localparam int SIG_CLK   = 0;
  localparam int SIG_HS    = 1;
  localparam int SIG_VS    = 2;
  localparam int SIG_BLANK = 3;
  localparam int SIG_N     = 4;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_sync_decoder_if.sv
// VGA timing inputs and decoded outputs; the master drives the VGA side,
// the slave is the decoder.
interface vga_sync_decoder_if;
  import vga_sync_decoder_pkg::*;

  logic             vga_clk;
  logic             vga_hs;
  logic             vga_vs;
  logic             vga_blank_n;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             ativo;
  logic             frame_start;
  logic             locked;
  logic [1:0]       err;
  logic [FC_W-1:0]  frame_count;

  modport master (
    output vga_clk, vga_hs, vga_vs, vga_blank_n,
    input  x, y, ativo, frame_start, locked, err, frame_count
  );

  modport slave (
    input  vga_clk, vga_hs, vga_vs, vga_blank_n,
    output x, y, ativo, frame_start, locked, err, frame_count
  );

endinterface

// File: rtl/vga_sync_decoder_edge_detect.sv
// Samples one VGA input and flags its rising/falling transition between
// consecutive samples.
module vga_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      d_q    <= d_i;
      prev_q <= d_q;
    end
  end

  assign q_o    = d_q;
  assign rise_o = d_q & ~prev_q;
  assign fall_o = ~d_q & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from a VGA sync stream and verifies line/frame
// timing before declaring lock.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  vga_sync_decoder_if.slave  bus
);

  localparam int LW = CNT_W + 1;
  localparam logic [LW-1:0]    H_TOTAL_W   = LW'(H_TOTAL);
  localparam logic [LW-1:0]    V_TOTAL_W   = LW'(V_TOTAL);
  localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACTIVE_W  = CNT_W'(V_ACTIVE);

  logic [SIG_N-1:0] raw_in, smp, rise, fall;

  assign raw_in = {bus.vga_blank_n, bus.vga_vs, bus.vga_hs, bus.vga_clk};

  for (genvar gi = 0; gi < SIG_N; gi++) begin : g_edge
    vga_edge_detect u_edge (
      .clk    (CLOCK_50),
      .rst_n  (reset),
      .d_i    (raw_in[gi]),
      .q_o    (smp[gi]),
      .rise_o (rise[gi]),
      .fall_o (fall[gi])
    );
  end

  // Edges the decoder has no use for
  logic unused_edges;
  assign unused_edges = &{1'b0, smp[SIG_VS:SIG_CLK], rise[SIG_VS:SIG_HS], fall[SIG_CLK]};

  logic tick, hs_as, vs_as, bl_rise, bl_fall, blank_q;
  assign tick    = rise[SIG_CLK];
  assign hs_as   = tick & fall[SIG_HS];
  assign vs_as   = tick & fall[SIG_VS];
  assign bl_rise = tick & rise[SIG_BLANK];
  assign bl_fall = tick & fall[SIG_BLANK];
  assign blank_q = smp[SIG_BLANK];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]       err_q, err_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic             fs_q, fs_d, locked_q, locked_d, ativo_q, ativo_d;
  logic             line_bad, frame_bad, run_bad, rows_bad;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    fc_d    = fc_q;
    fs_d    = 1'b0;

    line_bad  = hs_as && (({1'b0, h_cnt_q} + LW'(1)) != H_TOTAL_W);
    frame_bad = vs_as && (({1'b0, v_cnt_q} + LW'(1)) != V_TOTAL_W);
    run_bad   = tick && blank_q && !bl_rise && (x_q == H_ACT_LAST);
    rows_bad  = bl_rise && (y_q >= V_ACTIVE_W);

    if (hs_as)      h_cnt_d = '0;
    else if (tick)  h_cnt_d = sat_inc(h_cnt_q);

    if (vs_as)      v_cnt_d = '0;
    else if (hs_as) v_cnt_d = sat_inc(v_cnt_q);

    if (bl_rise)               x_d = '0;
    else if (tick && blank_q)  x_d = x_q + CNT_W'(1);

    if (vs_as)        y_d = '0;
    else if (bl_fall) y_d = y_q + CNT_W'(1);

    // Line and frame checks are independent so a coincident HS/VS can flag both
    unique case (state_q)
      SEARCH: begin
        if (vs_as) state_d = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (line_bad || run_bad)   err_d[0] = 1'b1;
        if (frame_bad || rows_bad) err_d[1] = 1'b1;
        if (line_bad || run_bad || frame_bad || rows_bad) begin
          state_d = SEARCH;
        end else if (vs_as) begin
          state_d = LOCKED;
          if (state_q == LOCKED) begin
            fs_d = 1'b1;
            fc_d = fc_q + FC_W'(1);
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    locked_d = (state_d == LOCKED);
    ativo_d  = blank_q && locked_d;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= SEARCH;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      err_q    <= '0;
      fc_q     <= '0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      ativo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      err_q    <= err_d;
      fc_q     <= fc_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      ativo_q  <= ativo_d;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.ativo       = ativo_q;
  assign bus.frame_start = fs_q;
  assign bus.locked      = locked_q;
  assign bus.err         = err_q;
  assign bus.frame_count = fc_q;

  // Alias kept so the frame counter can be referred to by its role
  logic [FC_W-1:0] frame_count_q;
  assign frame_count_q = fc_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder driven by a small behavioural VGA
// timing generator with scaled-down line/frame sizes.
module tb_vga_sync_decoder;
  import vga_sync_decoder_pkg::*;

  localparam int H_TOTAL  = 20;
  localparam int V_TOTAL  = 10;
  localparam int H_ACTIVE = 12;
  localparam int V_ACTIVE = 6;
  localparam int H_BP     = 4;
  localparam int V_BP     = 2;

  logic CLOCK_50;
  logic reset;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  // Generator position of the next tick to emit
  int hc = 0;
  int vc = 1;
  int short_vc = -1;
  bit short_frame = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] %s ok: %0h", tag, obs);
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string ctx);
    chk({ctx, "_x"},           32'(bus.x), 0);
    chk({ctx, "_y"},           32'(bus.y), 0);
    chk({ctx, "_ativo"},       32'(bus.ativo), 0);
    chk({ctx, "_frame_start"}, 32'(bus.frame_start), 0);
    chk({ctx, "_locked"},      32'(bus.locked), 0);
    chk({ctx, "_err"},         32'(bus.err), 0);
    chk({ctx, "_frame_count"}, 32'(bus.frame_count), 0);
  endtask

  // One pixel tick: vga_clk high for one CLOCK_50 cycle, low for one; returns
  // #1 after the edge on which the decoder outputs for this tick settle.
  task automatic gen_tick();
    logic hs, vs, bl;
    int hlen, vlen;
    hs = !(hc < 2);
    vs = !(vc < 1);
    bl = (hc >= H_BP) && (hc < H_BP + H_ACTIVE) && (vc >= V_BP) && (vc < V_BP + V_ACTIVE);
    @(negedge CLOCK_50);
    bus.vga_clk = 1'b1;
    bus.vga_hs = hs;
    bus.vga_vs = vs;
    bus.vga_blank_n = bl;
    @(negedge CLOCK_50);
    bus.vga_clk = 1'b0;
    @(posedge CLOCK_50);
    #1;
    hlen = (vc == short_vc) ? H_TOTAL - 1 : H_TOTAL;
    vlen = short_frame ? V_TOTAL - 1 : V_TOTAL;
    if (hc + 1 >= hlen) begin
      hc = 0;
      if (vc == short_vc) short_vc = -1;
      if (vc + 1 >= vlen) begin
        vc = 0;
        short_frame = 1'b0;
      end else begin
        vc++;
      end
    end else begin
      hc++;
    end
  endtask

  task automatic run_until(input int tvc, input int thc);
    int n = 0;
    while (!(vc == tvc && hc == thc) && n < 5000) begin
      gen_tick();
      n++;
    end
    chk("reach_position", 32'(vc == tvc && hc == thc), 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.vga_clk = 1'b0;
    bus.vga_hs = 1'b1;
    bus.vga_vs = 1'b1;
    bus.vga_blank_n = 1'b0;
    #3 reset = 1'b0;
    #3;
    chk_zero("por");
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (4) @(negedge CLOCK_50);

    // Lock acquisition: VS1 starts measuring, VS2 locks
    run_until(0, 0);
    chk("pre_vs1_locked", 32'(bus.locked), 0);
    gen_tick();
    chk("vs1_locked", 32'(bus.locked), 0);
    run_until(0, 0);
    chk("pre_vs2_locked", 32'(bus.locked), 0);
    gen_tick();
    chk("vs2_locked", 32'(bus.locked), 1);
    chk("vs2_err", 32'(bus.err), 0);

    // Coordinates in the first locked frame
    run_until(V_BP, H_BP);
    gen_tick();
    chk("first_px_x", 32'(bus.x), 0);
    chk("first_px_y", 32'(bus.y), 0);
    chk("first_px_ativo", 32'(bus.ativo), 1);
    run_until(V_BP + V_ACTIVE - 1, H_BP + H_ACTIVE - 1);
    gen_tick();
    chk("last_px_x", 32'(bus.x), H_ACTIVE - 1);
    chk("last_px_y", 32'(bus.y), V_ACTIVE - 1);
    chk("last_px_ativo", 32'(bus.ativo), 1);
    gen_tick();
    chk("blank_x_hold", 32'(bus.x), H_ACTIVE - 1);
    chk("blank_y_inc", 32'(bus.y), V_ACTIVE);
    chk("blank_ativo", 32'(bus.ativo), 0);

    // Third VS: first counted locked frame
    run_until(0, 0);
    gen_tick();
    chk("vs3_frame_start", 32'(bus.frame_start), 1);
    chk("vs3_frame_count", 32'(bus.frame_count), 1);
    chk("vs3_err", 32'(bus.err), 0);
    chk("vs3_locked", 32'(bus.locked), 1);
    @(posedge CLOCK_50);
    #1;
    chk("vs3_fs_one_cycle", 32'(bus.frame_start), 0);

    // Short line (H_TOTAL-1 ticks) on line 3
    short_vc = 3;
    run_until(4, 0);
    chk("pre_short_locked", 32'(bus.locked), 1);
    chk("pre_short_err", 32'(bus.err), 0);
    gen_tick();
    chk("short_line_err", 32'(bus.err), 2'b01);
    chk("short_line_locked", 32'(bus.locked), 0);

    // Relock, then a frame one line short
    run_until(0, 0);
    gen_tick();
    chk("relock_measure", 32'(bus.locked), 0);
    run_until(0, 0);
    gen_tick();
    chk("relock_locked", 32'(bus.locked), 1);
    chk("relock_fc", 32'(bus.frame_count), 1);
    short_frame = 1'b1;
    run_until(0, 0);
    gen_tick();
    chk("short_frame_err", 32'(bus.err), 2'b11);
    chk("short_frame_state", 32'(dut.state_q), 32'(SEARCH));
    chk("short_frame_locked", 32'(bus.locked), 0);
    chk("short_frame_fc_held", 32'(bus.frame_count), 1);

    // Frame counter wrap
    run_until(0, 0);
    gen_tick();
    run_until(0, 0);
    gen_tick();
    chk("wrap_locked", 32'(bus.locked), 1);
    force dut.fc_q = 16'hFFFF;
    @(posedge CLOCK_50);
    #1;
    release dut.fc_q;
    chk("preload_fc", 32'(bus.frame_count), 32'h0000_FFFF);
    run_until(0, 0);
    gen_tick();
    chk("wrap_fc", 32'(bus.frame_count), 0);
    chk("wrap_fs", 32'(bus.frame_start), 1);
    @(posedge CLOCK_50);
    #1;
    chk("wrap_fs_one_cycle", 32'(bus.frame_start), 0);

    // Asynchronous reset in the middle of an active line
    run_until(3, 8);
    gen_tick();
    chk("pre_reset_ativo", 32'(bus.ativo), 1);
    #2 reset = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b1;
    run_until(0, 0);
    chk("post_rst_pre_vs", 32'(bus.locked), 0);
    gen_tick();
    chk("post_rst_vs1", 32'(bus.locked), 0);
    run_until(0, 0);
    chk("post_rst_pre_vs2", 32'(bus.locked), 0);
    gen_tick();
    chk("post_rst_vs2", 32'(bus.locked), 1);
    chk("post_rst_err", 32'(bus.err), 0);
    chk("post_rst_fc", 32'(bus.frame_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
